// File: rtl/fft_mem_pkg.sv
// Shared definitions for the sample DMA path into processor data memory:
// default RAM geometry and the DMA controller state encoding.
package fft_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dma_state_t;

    // A new frame may only be armed while no frame is being captured.
    function automatic logic start_allowed(input dma_state_t state);
        return (state != ST_RUN);
    endfunction

endpackage

// File: rtl/sample_addr_gen.sv
// Frame bookkeeping for the sample DMA writer: latches base/length on start,
// counts accepted samples and produces the wrapped RAM write address.
module sample_addr_gen
    import fft_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic              step,
    input  logic              wrap_en,
    output logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_reg  <= '0;
            len_reg   <= '0;
            count_reg <= '0;
        end else if (load) begin
            base_reg  <= base_addr;
            len_reg   <= frame_len;
            count_reg <= '0;
        end else if (step) begin
            // In circular capture the count restarts so the next frame overwrites from base.
            count_reg <= (last && wrap_en) ? '0 : count_reg + ONE;
        end
    end

    assign last  = (count_reg == len_reg - ONE);
    assign addr  = base_reg + count_reg;
    assign count = count_reg;

endmodule

// File: rtl/sample_dma_writer.sv
// Streams valid/ready samples into processor dmem at a programmed base address,
// yielding the RAM port to the processor whenever it accesses memory.
// Optional macro SAMPLE_DMA_CIRC_EN: circular capture with a 'stop' input.
module sample_dma_writer
    import fft_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
`ifdef SAMPLE_DMA_CIRC_EN
    input  logic              stop,
`endif
    input  logic              cpu_mem_en,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

`ifdef SAMPLE_DMA_CIRC_EN
    localparam logic CIRC_EN = 1'b1;
    logic stop_req;
    assign stop_req = stop;
`else
    localparam logic CIRC_EN = 1'b0;
    logic stop_req;
    assign stop_req = 1'b0;
`endif

    dma_state_t        state_reg, state_next;
    logic              done_reg, done_next;
    logic              start_ok;
    logic              transfer;
    logic              last;
    logic [ADDR_W-1:0] dma_addr;

    assign start_ok = start && start_allowed(state_reg);
    assign s_ready  = (state_reg == ST_RUN) && !cpu_mem_en;
    assign transfer = s_valid && s_ready;

    sample_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load      (start_ok),
        .base_addr (base_addr),
        .frame_len (frame_len),
        .step      (transfer),
        .wrap_en   (CIRC_EN),
        .count     (count),
        .addr      (dma_addr),
        .last      (last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = done_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    // An empty frame completes immediately without touching RAM.
                    state_next = (frame_len == '0) ? ST_DONE : ST_RUN;
                    done_next  = (frame_len == '0);
                end
            end
            ST_RUN: begin
                if (transfer && last) begin
                    done_next = 1'b1;
                    if (!CIRC_EN) begin
                        state_next = ST_DONE;
                    end
                end
                if (stop_req) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Zero-latency port mux: the processor always owns the RAM when it asks for it.
    always_comb begin
        ram_wren = transfer;
        ram_addr = dma_addr;
        ram_data = s_data;
        if (cpu_mem_en) begin
            ram_wren = cpu_wren;
            ram_addr = cpu_addr;
            ram_data = cpu_data;
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = done_reg;

endmodule
